// File: rtl/read_pkg.sv
// Shared state encoding and default buffer depth for the DMA read engine.
package read_pkg;

   localparam int RD_BUF_DEPTH_DEFAULT = 8;

   typedef logic [1:0] read_state_t;
   localparam read_state_t RD_IDLE    = 2'd0;
   localparam read_state_t RD_ASK     = 2'd1;
   localparam read_state_t RD_GRANTED = 2'd2;

endpackage

// File: rtl/rd_fifo.sv
// Synchronous FIFO holding returned read words; DEPTH must be a power of 2.
module rd_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [W-1:0]  data_i,
   input  logic          pop_i,
   output logic [W-1:0]  data_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/dma_read_engine.sv
// Single-command DMA read engine: arbitrates for the bus, issues word reads into a
// bounded buffer and streams them out. DMA_RD_ALIGN_CHECK_EN rejects misaligned commands.
module dma_read_engine
   import read_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int LEN_W     = 8,
   parameter int BUF_DEPTH = RD_BUF_DEPTH_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              bus_req,
   input  logic              bus_grant,
   output logic              bus_rd_en,
   output logic [ADDR_W-1:0] bus_addr,
   input  logic              bus_rvalid,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              err,
   output read_state_t       dbg_state
);

   localparam int STEP  = DATA_W / 8;
   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);

   // Handshakes: cmd and out transfer on a cycle where valid and ready are both high;
   // valid never depends on ready. bus_rd_en is a one-cycle issue that is only raised
   // while bus_grant is high; bus_rvalid returns data in issue order with any latency.

   read_state_t       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  issue_left_q, issue_left_d;
   logic [LEN_W-1:0]  pop_left_q, pop_left_d;
   logic [CNT_W-1:0]  outst_q, outst_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_data;
   logic [CNT_W:0]    occupancy;
   logic              push, pop, issue, cmd_bad;

   // Reads only return for words we issued; anything else (e.g. after a reset) is dropped.
   assign push      = bus_rvalid && (outst_q != '0);
   assign pop       = !fifo_empty && out_ready;
   assign occupancy = {1'b0, fifo_count} + {1'b0, outst_q};
   assign issue     = (state_q == RD_GRANTED) && (issue_left_q != '0) && bus_grant &&
                      (occupancy < DEPTH_C);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      issue_left_d = issue_left_q;
      pop_left_d   = pop_left_q;
      done_d       = 1'b0;
      bus_req      = 1'b0;
      case (state_q)
         RD_IDLE: begin
            if (cmd_valid) begin
               addr_d       = cmd_addr;
               issue_left_d = cmd_len;
               pop_left_d   = cmd_len;
               if (!cmd_bad) begin
                  if (cmd_len == '0) done_d  = 1'b1;
                  else               state_d = RD_ASK;
               end
            end
         end
         RD_ASK: begin
            bus_req = 1'b1;
            if (bus_grant) state_d = RD_GRANTED;
         end
         RD_GRANTED: begin
            if (issue_left_q != '0) begin
               bus_req = 1'b1;
               if (!bus_grant) state_d = RD_ASK;
            end
            if (pop && (pop_left_q == LEN_W'(1))) begin
               state_d = RD_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = RD_IDLE;
      endcase
      if (issue) begin
         addr_d       = addr_q + ADDR_W'(STEP);
         issue_left_d = issue_left_q - LEN_W'(1);
      end
      if (pop) pop_left_d = pop_left_q - LEN_W'(1);
      outst_d = outst_q + CNT_W'(issue) - CNT_W'(push);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RD_IDLE;
         addr_q       <= '0;
         issue_left_q <= '0;
         pop_left_q   <= '0;
         outst_q      <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         issue_left_q <= issue_left_d;
         pop_left_q   <= pop_left_d;
         outst_q      <= outst_d;
         done_q       <= done_d;
      end
   end

`ifdef DMA_RD_ALIGN_CHECK_EN
   logic err_q;
   assign cmd_bad = (cmd_addr % ADDR_W'(STEP)) != '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= (state_q == RD_IDLE) && cmd_valid && cmd_bad;
   end
   assign err = err_q;
`else
   assign cmd_bad = 1'b0;
   assign err     = 1'b0;
`endif

   rd_fifo #(
      .W     (DATA_W),
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  (bus_rdata),
      .pop_i   (pop),
      .data_o  (fifo_data),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign cmd_ready = (state_q == RD_IDLE);
   assign busy      = (state_q != RD_IDLE);
   assign done      = done_q;
   assign bus_rd_en = issue;
   assign bus_addr  = addr_q;
   assign out_valid = !fifo_empty;
   // Head is the final word exactly when one word of the command is left to pop.
   assign out_last  = !fifo_empty && (pop_left_q == LEN_W'(1));
   assign out_data  = fifo_empty ? '0 : fifo_data;
   assign dbg_state = state_q;

   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_dma_read_engine.sv
// Bench for dma_read_engine: directed commands, a bus responder/arbiter model and a
// per-cycle compare against a transaction-level model of the expected word stream.
module tb_dma_read_engine;
   import read_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 8;
   localparam int DEPTH  = 8;
   localparam int STEP   = 4;
   localparam logic [DATA_W-1:0] RD_XOR = 32'hA5A5_0000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [LEN_W-1:0]  cmd_len = '0;
   logic              bus_req;
   logic              bus_grant = 1'b0;
   logic              bus_rd_en;
   logic [ADDR_W-1:0] bus_addr;
   logic              bus_rvalid = 1'b0;
   logic [DATA_W-1:0] bus_rdata = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;
   logic              done;
   logic              err;
   read_state_t       dbg_state;

   always #5 clk = ~clk;

   dma_read_engine #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .LEN_W     (LEN_W),
      .BUF_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_len    (cmd_len),
      .bus_req    (bus_req),
      .bus_grant  (bus_grant),
      .bus_rd_en  (bus_rd_en),
      .bus_addr   (bus_addr),
      .bus_rvalid (bus_rvalid),
      .bus_rdata  (bus_rdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .dbg_state  (dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Transaction-level model state
   logic [ADDR_W-1:0] exp_addr_q[$];
   logic [DATA_W:0]   exp_q[$];
   logic [DATA_W:0]   e;
   logic [ADDR_W-1:0] issue_log[$];
   logic [DATA_W-1:0] last_data = '0;
   int  model_busy = 0;
   int  model_buf  = 0;
   int  issue_cnt  = 0;
   int  pop_cnt    = 0;
   int  done_seen  = 0;
   int  last_seen  = 0;
   bit  done_due   = 0;
   bit  err_due    = 0;
   bit  mon_en     = 0;
   bit  acc_bad    = 0;

   // Bus responder and arbiter state
   logic [ADDR_W-1:0] pend_addr[$];
   int  pend_due[$];
   int  rsp_lat     = 1;
   int  grant_delay = 2;
   bit  grant_block = 0;
   int  req_cnt     = 0;
   int  cyc         = 0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      bus_rvalid = 1'b0;
      if (!rst_n) begin
         bus_grant = 1'b0;
         req_cnt   = 0;
         pend_addr.delete();
         pend_due.delete();
      end else begin
         if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            bus_rvalid = 1'b1;
            bus_rdata  = pend_addr.pop_front() ^ RD_XOR;
            void'(pend_due.pop_front());
         end
         if (bus_req) req_cnt++;
         else         req_cnt = 0;
         bus_grant = bus_req && !grant_block && (req_cnt >= grant_delay);
      end
   end

   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         check("done", done, done_due);
         check("err", err, err_due);
         check("busy", busy, model_busy != 0);
         check("cmd_ready", cmd_ready, model_busy == 0);
         check("bus_req", bus_req, (model_busy != 0) && (exp_addr_q.size() != 0));
         check("out_valid", out_valid, model_buf > 0);
         done_due = 0;
         err_due  = 0;
         if (done) done_seen++;
         if (bus_rd_en) begin
            check("issue_grant", bus_grant, 1'b1);
            check("issue_window", (issue_cnt - pop_cnt) < DEPTH, 1'b1);
            check("issue_expected", exp_addr_q.size() != 0, 1'b1);
            if (exp_addr_q.size() != 0) check("bus_addr", bus_addr, exp_addr_q.pop_front());
            issue_log.push_back(bus_addr);
            pend_addr.push_back(bus_addr);
            pend_due.push_back(cyc + rsp_lat);
            issue_cnt++;
         end
         if (out_valid && out_ready) begin
            check("pop_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("out_data", out_data, e[DATA_W-1:0]);
               check("out_last", out_last, e[DATA_W]);
               if (e[DATA_W]) begin
                  done_due   = 1;
                  model_busy = 0;
               end
            end
            if (out_last) begin
               last_seen++;
               last_data = out_data;
            end
            model_buf--;
            pop_cnt++;
         end else if (out_valid && exp_q.size() != 0) begin
            check("out_last_hold", out_last, exp_q[0][DATA_W]);
         end
         if (bus_rvalid) model_buf++;
         if (cmd_valid && cmd_ready) begin
            acc_bad = 0;
`ifdef DMA_RD_ALIGN_CHECK_EN
            acc_bad = (cmd_addr % STEP) != 0;
`endif
            if (acc_bad) err_due = 1;
            else if (cmd_len == 0) done_due = 1;
            else begin
               model_busy = 1;
               for (int i = 0; i < int'(cmd_len); i++) begin
                  exp_addr_q.push_back(cmd_addr + ADDR_W'(i * STEP));
                  exp_q.push_back({(i == int'(cmd_len) - 1), (cmd_addr + ADDR_W'(i * STEP)) ^ RD_XOR});
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
      int k = 0;
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = l;
      while (!cmd_ready && k < 200) begin
         tick();
         k++;
      end
      check("cmd_accept_in_time", k < 200, 1'b1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while ((busy || model_busy != 0) && k < budget) begin
         tick();
         k++;
      end
      check("idle_in_time", k < budget, 1'b1);
      tick();
   endtask

   task automatic wait_issues(input int target, input int budget);
      int k = 0;
      do begin
         @(negedge clk);
         #1;
         k++;
      end while (issue_cnt < target && k < budget);
      check("issues_in_time", k < budget, 1'b1);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
      check({tag, "_bus_req"}, bus_req, 1'b0);
      check({tag, "_bus_rd_en"}, bus_rd_en, 1'b0);
      check({tag, "_bus_addr"}, bus_addr, 32'h0);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_out_data"}, out_data, 32'h0);
      check({tag, "_out_last"}, out_last, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_err"}, err, 1'b0);
      check({tag, "_state"}, dbg_state, RD_IDLE);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, d0, l0, p0;
      repeat (3) tick();
      reset_checks("reset");
      rst_n  = 1'b1;
      mon_en = 1;
      tick();

      // Basic 4-word read, grant after 2 cycles, 1-cycle read latency
      out_ready = 1'b1;
      b = issue_log.size(); d0 = done_seen; l0 = last_seen;
      send_cmd(32'h100, 8'd4);
      wait_idle(100);
      check("t1_issue_count", issue_log.size() - b, 4);
      check("t1_addr0", issue_log[b+0], 32'h100);
      check("t1_addr1", issue_log[b+1], 32'h104);
      check("t1_addr2", issue_log[b+2], 32'h108);
      check("t1_addr3", issue_log[b+3], 32'h10C);
      check("t1_done_once", done_seen - d0, 1);
      check("t1_last_once", last_seen - l0, 1);
      check("t1_last_data", last_data, 32'hA5A5_010C);

      // Downstream stalled: issue stops at buffer depth
      out_ready = 1'b0;
      b = issue_log.size(); p0 = pop_cnt;
      send_cmd(32'h2000, 8'd12);
      repeat (40) tick();
      check("t2_stall_issues", issue_log.size() - b, 8);
      check("t2_stall_valid", out_valid, 1'b1);
      check("t2_stall_head", out_data, 32'hA5A5_2000);
      check("t2_stall_busy", busy, 1'b1);
      out_ready = 1'b1;
      wait_idle(200);
      check("t2_total_issues", issue_log.size() - b, 12);
      check("t2_total_pops", pop_cnt - p0, 12);
      check("t2_addr11", issue_log[b+11], 32'h202C);

      // Grant withdrawn after the second issue
      b = issue_log.size();
      cmd_valid = 1'b1; cmd_addr = 32'h3000; cmd_len = 8'd5;
      tick();
      cmd_valid = 1'b0;
      wait_issues(b + 2, 100);
      grant_block = 1;
      check("t3_issues_at_block", issue_log.size() - b, 2);
      repeat (3) tick();
      check("t3_state_ask", dbg_state, RD_ASK);
      check("t3_req_held", bus_req, 1'b1);
      check("t3_no_more_issues", issue_log.size() - b, 2);
      grant_block = 0;
      wait_idle(100);
      check("t3_total_issues", issue_log.size() - b, 5);
      check("t3_resume_addr", issue_log[b+2], 32'h3008);
      check("t3_final_addr", issue_log[b+4], 32'h3010);

      // Zero-length command
      b = issue_log.size(); d0 = done_seen;
      send_cmd(32'h400, 8'd0);
      check("t4_done_next", done, 1'b1);
      check("t4_no_req", bus_req, 1'b0);
      check("t4_not_busy", busy, 1'b0);
      tick();
      check("t4_done_single", done, 1'b0);
      repeat (3) tick();
      check("t4_no_issue", issue_log.size() - b, 0);

      // Reset with three reads outstanding
      rsp_lat = 20;
      b = issue_log.size();
      cmd_valid = 1'b1; cmd_addr = 32'h5000; cmd_len = 8'd6;
      tick();
      cmd_valid = 1'b0;
      wait_issues(b + 3, 100);
      grant_block = 1;
      repeat (2) tick();
      check("t5_outstanding", issue_log.size() - b, 3);
      check("t5_busy_before", busy, 1'b1);
      mon_en = 0;
      rst_n  = 1'b0;
      #1;
      reset_checks("t5_reset");
      exp_addr_q.delete();
      exp_q.delete();
      model_busy = 0; model_buf = 0; issue_cnt = 0; pop_cnt = 0;
      done_due = 0; err_due = 0;
      grant_block = 0;
      rsp_lat = 1;
      repeat (3) tick();
      rst_n  = 1'b1;
      mon_en = 1;
      tick();
      reset_checks("t5_after");
      b = issue_log.size(); d0 = done_seen;
      send_cmd(32'h6000, 8'd2);
      wait_idle(100);
      check("t5_new_issues", issue_log.size() - b, 2);
      check("t5_new_addr0", issue_log[b+0], 32'h6000);
      check("t5_new_addr1", issue_log[b+1], 32'h6004);
      check("t5_new_done", done_seen - d0, 1);

      // Misaligned start address
      b = issue_log.size(); d0 = done_seen;
      send_cmd(32'h102, 8'd2);
`ifdef DMA_RD_ALIGN_CHECK_EN
      check("t6_err_pulse", err, 1'b1);
      check("t6_no_req", bus_req, 1'b0);
      check("t6_idle", busy, 1'b0);
      tick();
      check("t6_err_single", err, 1'b0);
      repeat (4) tick();
      check("t6_no_issue", issue_log.size() - b, 0);
      check("t6_no_done", done_seen - d0, 0);
`else
      wait_idle(100);
      check("t6_issues", issue_log.size() - b, 2);
      check("t6_addr0", issue_log[b+0], 32'h102);
      check("t6_addr1", issue_log[b+1], 32'h106);
      check("t6_done", done_seen - d0, 1);
`endif

      // Address wrap with toggling downstream ready and longer latency
      begin
         int k = 0;
         rsp_lat = 3;
         b = issue_log.size();
         send_cmd(32'hFFFF_FFF8, 8'd5);
         while ((busy || model_busy != 0) && k < 400) begin
            out_ready = ~out_ready;
            tick();
            k++;
         end
         check("t7_idle_in_time", k < 400, 1'b1);
         out_ready = 1'b1;
         tick();
         check("t7_issues", issue_log.size() - b, 5);
         check("t7_addr_wrap", issue_log[b+2], 32'h0);
         check("t7_addr_last", issue_log[b+4], 32'h8);
      end

      check("end_model_empty", exp_q.size(), 0);
      check("end_addr_empty", exp_addr_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
